riscv_imem_loader_ctrl: RTL and testbench
=========================================

# riscv_imem_loader_ctrl

Controller placed in front of the instruction memory. It owns the single memory port: after reset it holds the core and fills the memory from a byte stream, for example a UART boot loader. It then hands the port to the fetch stage for zero-latency reads. A reload can be requested at any time while running.

## Interface
- `XLEN`, 32, instruction/data word width; must be 32.
- `IMEM_ADDR_BIT`, 12, byte-address width of the instruction memory; depth = 2^(IMEM_ADDR_BIT-2) words.
- `BOOT_LOAD`, 1, 1: reset enters LOAD; 0: reset enters RUN, for a pre-initialised memory.
- `NOP_INSN`, 32'h00000013, word returned to fetch while the core is held.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_fetch_addr`  in  IMEM_ADDR_BIT  byte address from the PC.
- `o_fetch_data`  out  XLEN  instruction to the decoder.
- `o_fetch_misalign`  out  1  high when i_fetch_addr[1:0] != 0 in RUN.
- `o_core_hold`  out  1  core must stall/stay in reset while high.
- `i_ld_start`  in  1  pulse; begin a new load.
- `i_ld_valid`  in  1  byte present.
- `i_ld_byte`  in  8  load data; little-endian within a word.
- `i_ld_last`  in  1  qualifies the final byte; sampled only with valid.
- `o_ld_ready`  out  1  byte accepted when valid && ready.
- `o_ld_words`  out  IMEM_ADDR_BIT-1  words written by the current/last load.
- `o_ld_overflow`  out  1  sticky: bytes were dropped because the memory was full.
- `o_imem_addr`  out  IMEM_ADDR_BIT-2  word address to the memory.
- `o_imem_wdata`  out  XLEN  write data.
- `o_imem_we`  out  1  write strobe; the memory writes on the rising edge.
- `i_imem_rdata`  in  XLEN  asynchronous read data.

## Operation
- States:
  - LOAD: assembling bytes.
  - WRITE: one-cycle memory write.
  - RUN: fetch owns the port.
- Reset values:
  - state = LOAD if BOOT_LOAD, else RUN.
  - Write pointer 0, byte lane 0, o_ld_words 0, o_ld_overflow 0, o_imem_we 0, wdata register 0.
- o_core_hold = (state != RUN). o_ld_ready = (state == LOAD).
- **LOAD**, on each accepted byte:
  - Place the byte into lane `lane` of the word register; increment lane mod 4.
  - When the byte fills lane 3, or i_ld_last is set, go to WRITE. On i_ld_last, unfilled upper lanes are zero.
- **WRITE**:
  - o_imem_we = 1, o_imem_addr = write pointer, o_imem_wdata = word register.
  - On exit: pointer +1, o_ld_words +1, lane = 0, word register cleared.
  - Next state is RUN if the word was last, else LOAD.
- **Full memory**:
  - When the pointer equals the depth, accepted bytes are dropped and o_ld_overflow is set. o_ld_ready stays 1 so the source drains.
  - A last byte while full goes straight to RUN with no write.
- **RUN**:
  - o_imem_addr = i_fetch_addr[IMEM_ADDR_BIT-1:2].
  - o_fetch_data = i_imem_rdata, combinational.
  - o_imem_we = 0.
- **Not RUN**: o_fetch_data = NOP_INSN and o_fetch_misalign = 0.
- **i_ld_start** in any state:
  - Next state LOAD; pointer, lane, o_ld_words and o_ld_overflow are cleared.
  - A byte offered in the same cycle is discarded.
  - If it arrives in WRITE, that write still completes this cycle.
  - i_ld_start has priority over i_ld_last.
- i_ld_last with i_ld_valid low is ignored.
- A last byte that exactly completes a word causes one write, not an extra empty word.

## Timing
- Fetch read latency is 0 cycles in RUN: address to data is combinational.
- A byte accepted at edge n that completes a word:
  - o_imem_we is high in cycle n+1.
  - o_ld_ready is 0 in cycle n+1 and returns to 1 in n+2.
- Throughput: 4 bytes per 5 cycles at worst.
- Last word written in cycle k → o_core_hold falls at edge k+1; the first fetch is served in cycle k+1.
- o_ld_words and o_ld_overflow are registered and update the edge after their cause.
- Reset mid-load abandons the partial word: no write is issued, and state returns to the reset state.

## Test plan
- **Word assembly.** BOOT_LOAD=1; stream 13 00 00 00 93 00 10 00 (last on 8th byte).
  - mem[0]=00000013, mem[1]=00100093.
  - o_ld_words=2; o_core_hold falls one cycle after the second write.
- **Partial last word.** Stream AA BB CC (last on CC).
  - mem[0]=00CCBBAA, one write only, o_ld_words=1.
- **Fetch path.** In RUN, i_fetch_addr = 0x004 → o_fetch_data = mem[1].
  - i_fetch_addr = 0x006 → o_fetch_misalign = 1.
  - With o_core_hold = 1, o_fetch_data = 00000013.
- **Overflow.** IMEM_ADDR_BIT=4 (4 words); stream 20 bytes, last on 20th.
  - Exactly 4 writes; o_ld_overflow = 1, o_ld_words = 4, state RUN with no write for the dropped bytes.
- **Restart.** Send i_ld_start in RUN, then i_ld_start together with a valid byte mid-word.
  - Hold reasserts; the byte is discarded; pointer restarts at 0; overflow clears.
- **Reset mid-load.** Assert i_rst after 2 bytes.
  - o_imem_we never asserts; all outputs return to reset values.
  - With BOOT_LOAD=0, reset → o_core_hold = 0 immediately.

Source files
------------

// File: rtl/riscv_imem_loader_ctrl.sv
// Instruction-memory port owner: fills the memory from a byte stream after reset
// or on request, then hands the port to the fetch stage for zero-latency reads.
module riscv_imem_loader_ctrl #(
    parameter int unsigned         XLEN          = 32,
    parameter int unsigned         IMEM_ADDR_BIT = 12,
    parameter bit                  BOOT_LOAD     = 1'b1,
    parameter logic [XLEN-1:0]     NOP_INSN      = 32'h00000013
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [IMEM_ADDR_BIT-1:0] i_fetch_addr,
    output logic [XLEN-1:0]          o_fetch_data,
    output logic                     o_fetch_misalign,
    output logic                     o_core_hold,
    input  logic                     i_ld_start,
    input  logic                     i_ld_valid,
    input  logic [7:0]               i_ld_byte,
    input  logic                     i_ld_last,
    output logic                     o_ld_ready,
    output logic [IMEM_ADDR_BIT-2:0] o_ld_words,
    output logic                     o_ld_overflow,
    output logic [IMEM_ADDR_BIT-3:0] o_imem_addr,
    output logic [XLEN-1:0]          o_imem_wdata,
    output logic                     o_imem_we,
    input  logic [XLEN-1:0]          i_imem_rdata
);

    localparam int unsigned WORD_AW = IMEM_ADDR_BIT - 2;
    localparam int unsigned PTR_W   = IMEM_ADDR_BIT - 1;
    // Pointer is one bit wider than the word address so "full" is representable.
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {WORD_AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WRITE,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [1:0]        lane_q, lane_d;
    logic [XLEN-1:0]   word_q, word_d;
    logic [PTR_W-1:0]  words_q, words_d;
    logic              ovf_q, ovf_d;
    logic              last_q, last_d;
    logic              accept;
    logic              full;

    assign accept = i_ld_valid && (state_q == ST_LOAD);
    assign full   = (ptr_q == DEPTH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RESET_STATE;
            ptr_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lane_d  = lane_q;
        word_d  = word_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        last_d  = last_q;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (full) begin
                        // Keep draining the source; only a last byte ends the load.
                        ovf_d = 1'b1;
                        if (i_ld_last) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        word_d[{lane_q, 3'b000} +: 8] = i_ld_byte;
                        lane_d = lane_q + 2'd1;
                        if (lane_q == 2'd3 || i_ld_last) begin
                            state_d = ST_WRITE;
                            last_d  = i_ld_last;
                        end
                    end
                end
            end
            ST_WRITE: begin
                ptr_d   = ptr_q + PTR_W'(1);
                words_d = words_q + PTR_W'(1);
                lane_d  = '0;
                word_d  = '0;
                last_d  = 1'b0;
                state_d = last_q ? ST_RUN : ST_LOAD;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // A restart wins over everything; a write already on the port still lands.
        if (i_ld_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            lane_d  = '0;
            word_d  = '0;
            words_d = '0;
            ovf_d   = 1'b0;
            last_d  = 1'b0;
        end
    end

    assign o_core_hold      = (state_q != ST_RUN);
    assign o_ld_ready       = (state_q == ST_LOAD);
    assign o_imem_we        = (state_q == ST_WRITE);
    assign o_imem_wdata     = word_q;
    assign o_imem_addr      = (state_q == ST_RUN) ? i_fetch_addr[IMEM_ADDR_BIT-1:2]
                                                  : ptr_q[WORD_AW-1:0];
    assign o_fetch_data     = (state_q == ST_RUN) ? i_imem_rdata : NOP_INSN;
    assign o_fetch_misalign = (state_q == ST_RUN) && (i_fetch_addr[1:0] != 2'b00);
    assign o_ld_words       = words_q;
    assign o_ld_overflow    = ovf_q;

endmodule

// File: tb/tb_riscv_imem_loader_ctrl.sv
// Randomised bench for riscv_imem_loader_ctrl: three instances (boot-load 1K words,
// boot-load 4 words, pre-initialised) against memory models and a byte-stream model.
module tb_riscv_imem_loader_ctrl;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [11:0] fetch_addr = '0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_last = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        sel = 1'b0;   // 0: large instance receives the stream, 1: small instance

    logic        valid_a, valid_b, start_a, start_b;
    assign valid_a = ld_valid && !sel;
    assign valid_b = ld_valid && sel;
    assign start_a = ld_start && !sel;
    assign start_b = ld_start && sel;

    // Large instance, boot load
    logic [31:0] fdata_a, wdata_a, rdata_a;
    logic        mis_a, hold_a, rdy_a, ovf_a, we_a;
    logic [10:0] words_a;
    logic [9:0]  addr_a;
    logic [31:0] mem_a [0:1023];
    int          wr_a = 0;

    // Small instance, 4 words
    logic [31:0] fdata_b, wdata_b, rdata_b;
    logic        mis_b, hold_b, rdy_b, ovf_b, we_b;
    logic [2:0]  words_b;
    logic [1:0]  addr_b;
    logic [31:0] mem_b [0:3];
    int          wr_b = 0;

    // Pre-initialised instance
    logic [31:0] fdata_c, wdata_c;
    logic        mis_c, hold_c, rdy_c, ovf_c, we_c;
    logic [10:0] words_c;
    logic [9:0]  addr_c;

    logic        ready, hold;
    assign ready = sel ? rdy_b : rdy_a;
    assign hold  = sel ? hold_b : hold_a;

    assign rdata_a = mem_a[addr_a];
    assign rdata_b = mem_b[addr_b];

    always @(posedge clk) begin
        if (we_a) begin
            mem_a[addr_a] <= wdata_a;
            wr_a <= wr_a + 1;
        end
        if (we_b) begin
            mem_b[addr_b] <= wdata_b;
            wr_b <= wr_b + 1;
        end
    end

    riscv_imem_loader_ctrl #(.XLEN(32), .IMEM_ADDR_BIT(12), .BOOT_LOAD(1'b1), .NOP_INSN(32'h00000013)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_fetch_addr(fetch_addr),
        .o_fetch_data(fdata_a), .o_fetch_misalign(mis_a), .o_core_hold(hold_a),
        .i_ld_start(start_a), .i_ld_valid(valid_a), .i_ld_byte(ld_byte), .i_ld_last(ld_last),
        .o_ld_ready(rdy_a), .o_ld_words(words_a), .o_ld_overflow(ovf_a),
        .o_imem_addr(addr_a), .o_imem_wdata(wdata_a), .o_imem_we(we_a), .i_imem_rdata(rdata_a)
    );

    riscv_imem_loader_ctrl #(.XLEN(32), .IMEM_ADDR_BIT(4), .BOOT_LOAD(1'b1), .NOP_INSN(32'h00000013)) u_small (
        .i_clk(clk), .i_rst(rst), .i_fetch_addr(fetch_addr[3:0]),
        .o_fetch_data(fdata_b), .o_fetch_misalign(mis_b), .o_core_hold(hold_b),
        .i_ld_start(start_b), .i_ld_valid(valid_b), .i_ld_byte(ld_byte), .i_ld_last(ld_last),
        .o_ld_ready(rdy_b), .o_ld_words(words_b), .o_ld_overflow(ovf_b),
        .o_imem_addr(addr_b), .o_imem_wdata(wdata_b), .o_imem_we(we_b), .i_imem_rdata(rdata_b)
    );

    riscv_imem_loader_ctrl #(.XLEN(32), .IMEM_ADDR_BIT(12), .BOOT_LOAD(1'b0), .NOP_INSN(32'h00000013)) u_pre (
        .i_clk(clk), .i_rst(rst), .i_fetch_addr(fetch_addr),
        .o_fetch_data(fdata_c), .o_fetch_misalign(mis_c), .o_core_hold(hold_c),
        .i_ld_start(1'b0), .i_ld_valid(1'b0), .i_ld_byte(8'h00), .i_ld_last(1'b0),
        .o_ld_ready(rdy_c), .o_ld_words(words_c), .o_ld_overflow(ovf_c),
        .o_imem_addr(addr_c), .o_imem_wdata(wdata_c), .o_imem_we(we_c), .i_imem_rdata(32'hDEADBEEF)
    );

    // Byte stream under test and its expected memory image
    logic [7:0] stream [$];

    function automatic logic [31:0] model_word(input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned j = 0; j < 4; j++)
            if (4 * w + j < stream.size()) r[8*j +: 8] = stream[4*w + j];
        return r;
    endfunction

    function automatic int unsigned model_words(input int unsigned depth);
        int unsigned n;
        n = (stream.size() + 3) / 4;
        return (n > depth) ? depth : n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ld_valid = 1'b0; ld_start = 1'b0; ld_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic is_last);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL ready_timeout actual=%b required=1", ready);
        end
        ld_valid = 1'b1; ld_byte = b; ld_last = is_last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic send_stream(input bit gaps);
        for (int i = 0; i < stream.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(stream[i], i == stream.size() - 1);
        end
    endtask

    task automatic wait_run();
        int unsigned n;
        n = 0;
        while (hold !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL hold_release_timeout actual=%b required=0", hold);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        fetch_addr = 12'h006;
        #1;
        checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL rst_hold actual=%b required=1", hold_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL rst_ready actual=%b required=1", rdy_a); end
        checks++; if (words_a !== 11'd0) begin errors++; $display("FAIL rst_words actual=%0d required=0", words_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL rst_ovf actual=%b required=0", ovf_a); end
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL rst_we actual=%b required=0", we_a); end
        checks++; if (fdata_a !== 32'h00000013) begin errors++; $display("FAIL rst_nop actual=%h required=00000013", fdata_a); end
        checks++; if (mis_a !== 1'b0) begin errors++; $display("FAIL rst_misalign actual=%b required=0", mis_a); end
        checks++; if (hold_c !== 1'b0) begin errors++; $display("FAIL pre_hold actual=%b required=0", hold_c); end
        checks++; if (rdy_c !== 1'b0) begin errors++; $display("FAIL pre_ready actual=%b required=0", rdy_c); end
        checks++; if (fdata_c !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_fetch actual=%h required=deadbeef", fdata_c); end
        checks++; if (mis_c !== 1'b1) begin errors++; $display("FAIL pre_misalign actual=%b required=1", mis_c); end
    endtask

    task automatic test_word_assembly();
        int w0;
        logic [7:0] bytes [8];
        bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        sel = 1'b0;
        do_reset();
        w0 = wr_a;
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i], i == 7);
            if (i == 3) begin
                checks++; if (we_a !== 1'b1 || rdy_a !== 1'b0) begin errors++; $display("FAIL wa_write_cycle we=%b ready=%b required we=1 ready=0", we_a, rdy_a); end
                @(posedge clk); #1;
                checks++; if (rdy_a !== 1'b1 || we_a !== 1'b0) begin errors++; $display("FAIL wa_ready_back we=%b ready=%b required we=0 ready=1", we_a, rdy_a); end
            end
        end
        checks++; if (we_a !== 1'b1 || hold_a !== 1'b1) begin errors++; $display("FAIL wa_last_write we=%b hold=%b required we=1 hold=1", we_a, hold_a); end
        @(posedge clk); #1;
        checks++; if (hold_a !== 1'b0 || we_a !== 1'b0) begin errors++; $display("FAIL wa_hold_fall hold=%b we=%b required hold=0 we=0", hold_a, we_a); end
        checks++; if (mem_a[0] !== 32'h00000013) begin errors++; $display("FAIL wa_mem0 actual=%h required=00000013", mem_a[0]); end
        checks++; if (mem_a[1] !== 32'h00100093) begin errors++; $display("FAIL wa_mem1 actual=%h required=00100093", mem_a[1]); end
        checks++; if (words_a !== 11'd2) begin errors++; $display("FAIL wa_words actual=%0d required=2", words_a); end
        checks++; if (wr_a - w0 !== 2) begin errors++; $display("FAIL wa_writes actual=%0d required=2", wr_a - w0); end
    endtask

    task automatic test_partial();
        int w0;
        sel = 1'b0;
        do_reset();
        w0 = wr_a;
        // last without valid must be ignored
        @(negedge clk); ld_last = 1'b1;
        repeat (3) @(negedge clk);
        ld_last = 1'b0;
        checks++; if (hold_a !== 1'b1 || wr_a != w0) begin errors++; $display("FAIL pt_last_no_valid hold=%b writes=%0d required hold=1 writes=0", hold_a, wr_a - w0); end
        stream = '{8'hAA, 8'hBB, 8'hCC};
        send_stream(1'b0);
        wait_run();
        checks++; if (mem_a[0] !== 32'h00CCBBAA) begin errors++; $display("FAIL pt_mem0 actual=%h required=00ccbbaa", mem_a[0]); end
        checks++; if (wr_a - w0 !== 1) begin errors++; $display("FAIL pt_writes actual=%0d required=1", wr_a - w0); end
        checks++; if (words_a !== 11'd1) begin errors++; $display("FAIL pt_words actual=%0d required=1", words_a); end
    endtask

    task automatic test_fetch();
        logic [31:0] known [2];
        logic [11:0] a;
        known = '{32'h00CCBBAA, 32'h00100093};
        fetch_addr = 12'h004; #1;
        checks++; if (fdata_a !== 32'h00100093) begin errors++; $display("FAIL fe_data4 actual=%h required=00100093", fdata_a); end
        checks++; if (mis_a !== 1'b0) begin errors++; $display("FAIL fe_mis4 actual=%b required=0", mis_a); end
        fetch_addr = 12'h006; #1;
        checks++; if (mis_a !== 1'b1) begin errors++; $display("FAIL fe_mis6 actual=%b required=1", mis_a); end
        for (int i = 0; i < 8; i++) begin
            a = {9'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            fetch_addr = a; #1;
            checks++;
            if (fdata_a !== known[a[2]] || mis_a !== (a[1:0] != 2'b00) || addr_a !== a[11:2]) begin
                errors++;
                $display("FAIL fe_rand addr=%h data=%h mis=%b iaddr=%h required data=%h mis=%b", a, fdata_a, mis_a, addr_a, known[a[2]], a[1:0] != 2'b00);
            end
        end
    endtask

    task automatic test_random_load();
        int w0;
        int unsigned n, exp_w;
        sel = 1'b0;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            w0 = wr_a;
            n = $urandom_range(1, 40);
            stream.delete();
            for (int unsigned i = 0; i < n; i++) stream.push_back(8'($urandom));
            send_stream(1'b1);
            wait_run();
            exp_w = model_words(1024);
            checks++; if (words_a !== 11'(exp_w)) begin errors++; $display("FAIL rl_words actual=%0d required=%0d", words_a, exp_w); end
            checks++; if (wr_a - w0 != int'(exp_w)) begin errors++; $display("FAIL rl_writes actual=%0d required=%0d", wr_a - w0, exp_w); end
            checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL rl_ovf actual=%b required=0", ovf_a); end
            for (int unsigned w = 0; w < exp_w; w++) begin
                checks++;
                if (mem_a[w] !== model_word(w)) begin
                    errors++;
                    $display("FAIL rl_mem word=%0d actual=%h required=%h", w, mem_a[w], model_word(w));
                end
            end
        end
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        do_reset();
        stream.delete();
        for (int i = 0; i < 20; i++) stream.push_back(8'($urandom));
        send_stream(1'b0);
        @(posedge clk); #1;
        checks++; if (hold_b !== 1'b0) begin errors++; $display("FAIL ov_hold actual=%b required=0", hold_b); end
        checks++; if (wr_b !== 4) begin errors++; $display("FAIL ov_writes actual=%0d required=4", wr_b); end
        checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL ov_flag actual=%b required=1", ovf_b); end
        checks++; if (words_b !== 3'd4) begin errors++; $display("FAIL ov_words actual=%0d required=4", words_b); end
        for (int unsigned w = 0; w < 4; w++) begin
            checks++;
            if (mem_b[w] !== model_word(w)) begin errors++; $display("FAIL ov_mem word=%0d actual=%h required=%h", w, mem_b[w], model_word(w)); end
        end
        @(negedge clk); ld_start = 1'b1;
        @(posedge clk); #1; ld_start = 1'b0;
        checks++; if (ovf_b !== 1'b0 || words_b !== 3'd0 || hold_b !== 1'b1) begin errors++; $display("FAIL ov_restart ovf=%b words=%0d hold=%b required 0 0 1", ovf_b, words_b, hold_b); end
    endtask

    task automatic test_restart();
        int w0;
        sel = 1'b0;
        fetch_addr = 12'h006;
        w0 = wr_a;
        @(negedge clk); ld_start = 1'b1;
        @(posedge clk); #1; ld_start = 1'b0;
        checks++; if (hold_a !== 1'b1 || words_a !== 11'd0) begin errors++; $display("FAIL rs_start hold=%b words=%0d required hold=1 words=0", hold_a, words_a); end
        checks++; if (fdata_a !== 32'h00000013 || mis_a !== 1'b0) begin errors++; $display("FAIL rs_held_fetch data=%h mis=%b required 00000013 0", fdata_a, mis_a); end
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        @(negedge clk); ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h33;
        @(posedge clk); #1; ld_start = 1'b0; ld_valid = 1'b0;
        checks++; if (we_a !== 1'b0 || words_a !== 11'd0) begin errors++; $display("FAIL rs_start_byte we=%b words=%0d required 0 0", we_a, words_a); end
        stream = '{8'h44, 8'h55, 8'h66, 8'h77};
        send_stream(1'b1);
        wait_run();
        checks++; if (mem_a[0] !== 32'h77665544) begin errors++; $display("FAIL rs_mem0 actual=%h required=77665544", mem_a[0]); end
        checks++; if (words_a !== 11'd1 || wr_a - w0 != 1) begin errors++; $display("FAIL rs_count words=%0d writes=%0d required 1 1", words_a, wr_a - w0); end
    endtask

    task automatic test_start_in_write();
        int w0;
        sel = 1'b0;
        do_reset();
        w0 = wr_a;
        stream = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
        ld_start = 1'b1;   // asserted during the WRITE cycle
        @(posedge clk); #1; ld_start = 1'b0;
        checks++; if (wr_a - w0 != 1 || mem_a[0] !== 32'hD4C3B2A1) begin errors++; $display("FAIL sw_write writes=%0d mem0=%h required 1 d4c3b2a1", wr_a - w0, mem_a[0]); end
        checks++; if (words_a !== 11'd0 || hold_a !== 1'b1) begin errors++; $display("FAIL sw_cleared words=%0d hold=%b required 0 1", words_a, hold_a); end
        stream = '{8'h5A, 8'h6B};
        send_stream(1'b0);
        wait_run();
        checks++; if (mem_a[0] !== 32'h00006B5A || words_a !== 11'd1) begin errors++; $display("FAIL sw_reload mem0=%h words=%0d required 00006b5a 1", mem_a[0], words_a); end
    endtask

    task automatic test_reset_midload();
        int w0;
        sel = 1'b0;
        do_reset();
        w0 = wr_a;
        send_byte(8'hE1, 1'b0);
        send_byte(8'hE2, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (hold_c !== 1'b0) begin errors++; $display("FAIL rm_pre_hold actual=%b required=0", hold_c); end
        rst = 1'b0;
        checks++; if (wr_a != w0 || we_a !== 1'b0) begin errors++; $display("FAIL rm_no_write writes=%0d we=%b required 0 0", wr_a - w0, we_a); end
        checks++; if (hold_a !== 1'b1 || rdy_a !== 1'b1 || words_a !== 11'd0 || ovf_a !== 1'b0) begin errors++; $display("FAIL rm_state hold=%b ready=%b words=%0d ovf=%b required 1 1 0 0", hold_a, rdy_a, words_a, ovf_a); end
        stream = '{8'h01, 8'h02};
        send_stream(1'b0);
        wait_run();
        checks++; if (mem_a[0] !== 32'h00000201 || wr_a - w0 != 1) begin errors++; $display("FAIL rm_fresh mem0=%h writes=%0d required 00000201 1", mem_a[0], wr_a - w0); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_assembly();
        test_partial();
        test_fetch();
        test_restart();
        test_random_load();
        test_overflow();
        test_start_in_write();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
